// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: instruction format, HALT opcode, FSM states
// and the queue entry payload.
package fetch_ctrl_pkg;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 27;

   localparam logic [OPC_MSB-OPC_LSB:0] HALT = 5'h1F;

   typedef enum logic [1:0] {
      FS_IDLE      = 2'd0,
      FS_FETCH     = 2'd1,
      FS_HALT_WAIT = 2'd2,
      FS_HALTED    = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [WIDTH-1:0] inst;
      logic [PC_W-1:0]  pc;
   } fq_entry_t;

   function automatic logic is_halt(input logic [WIDTH-1:0] inst);
      return inst[OPC_MSB:OPC_LSB] == HALT;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry circular FIFO between fetch and decode, with a flush that
// discards everything in one cycle.
module fetch_queue #(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads instr_mem, buffers words for
// decode and handles redirects, HALT and out-of-range faults.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned BOOT_PC   = 0,
   parameter int unsigned MEM_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [PC_W-1:0]  imem_pc,
   input  logic [WIDTH-1:0] imem_inst,
   output logic             dec_valid,
   output logic [WIDTH-1:0] dec_inst,
   output logic [PC_W-1:0]  dec_pc,
   input  logic             dec_ready,
   input  logic             redirect_valid,
   input  logic [PC_W-1:0]  redirect_pc,
   output logic             halted,
   output logic             fault
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            fault_q, fault_d;
   logic            halted_q, halted_d;

   fq_entry_t       q_wdata, q_rdata;
   logic [1:0]      q_count;
   logic            q_push, q_pop, q_flush;
   logic            active, redirect, drained;

   fetch_queue #(
      .DATA_W ($bits(fq_entry_t))
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (q_push),
      .pop   (q_pop),
      .flush (q_flush),
      .wdata (q_wdata),
      .rdata (q_rdata),
      .count (q_count)
   );

   // Next state, PC and queue control; redirect outranks both fetch and pop.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      fault_d  = fault_q;
      q_push   = 1'b0;
      q_flush  = 1'b0;
      q_wdata  = '{inst: imem_inst, pc: pc_q};
      active   = (state_q == FS_FETCH) || (state_q == FS_HALT_WAIT);
      q_pop    = active && (q_count != 2'd0) && dec_ready;
      redirect = active && redirect_valid;
      drained  = (q_count == 2'd0) || ((q_count == 2'd1) && q_pop);

      case (state_q)
         FS_IDLE: begin
            if (start) begin
               pc_d    = PC_W'(BOOT_PC);
               state_d = FS_FETCH;
            end
         end
         FS_FETCH: begin
            if (redirect) begin
               q_flush = 1'b1;
               pc_d    = redirect_pc;
            end else if ((q_count < 2'd2) || q_pop) begin
               if (pc_q >= PC_W'(MEM_DEPTH)) begin
                  fault_d = 1'b1;
                  state_d = FS_HALT_WAIT;
               end else begin
                  q_push = 1'b1;
                  pc_d   = pc_q + PC_W'(1);
                  if (is_halt(imem_inst)) begin
                     state_d = FS_HALT_WAIT;
                  end
               end
            end
         end
         FS_HALT_WAIT: begin
            // A redirect revives fetch only when the stop came from HALT.
            if (redirect) begin
               q_flush = 1'b1;
               pc_d    = redirect_pc;
               if (!fault_q) begin
                  state_d = FS_FETCH;
               end
            end else if (drained) begin
               state_d = FS_HALTED;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase

      halted_d = (state_d == FS_HALTED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FS_IDLE;
         pc_q     <= '0;
         fault_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         fault_q  <= fault_d;
         halted_q <= halted_d;
      end
   end

   assign imem_pc   = pc_q;
   assign dec_valid = (q_count != 2'd0);
   assign dec_inst  = q_rdata.inst;
   assign dec_pc    = q_rdata.pc;
   assign halted    = halted_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the stimulus side predicts the in-order
// instruction stream, a negedge monitor checks every word decode accepts.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst, start, dec_ready, redirect_valid;
   logic        dec_valid, halted, fault;
   logic [31:0] imem_pc, imem_inst, dec_inst, dec_pc, redirect_pc;

   logic [31:0] mem [DEPTH];

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic exp_fault;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   halt_pop_cyc = -1;
   int   seen_cyc;
   logic [31:0] tgt;

   fetch_ctrl #(.BOOT_PC(0), .MEM_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .imem_pc        (imem_pc),
      .imem_inst      (imem_inst),
      .dec_valid      (dec_valid),
      .dec_inst       (dec_inst),
      .dec_pc         (dec_pc),
      .dec_ready      (dec_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .fault          (fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Asynchronous-read instruction memory; beyond the array returns filler.
   assign imem_inst = (imem_pc < DEPTH) ? mem[imem_pc[3:0]] : 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every accepted head must be the next predicted word.
   always @(negedge clk) begin
      if (!rst && dec_valid && dec_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_delivery: got pc 0x%0h, expected no delivery (cycle %0d)", dec_pc, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("dec_pc", 64'(dec_pc), 64'(mon_e.pc));
            check("dec_inst", 64'(dec_inst), 64'(mon_e.inst));
            if (mon_e.inst[31:27] == HALT) halt_pop_cyc = cyc;
         end
      end
   end

   // Program order from target: each word up to and including HALT; running
   // off the end of memory means a fault instead.
   task automatic build_stream(input logic [31:0] target);
      logic [31:0] p;
      p = target;
      sb.delete();
      exp_fault = 1'b0;
      while (1) begin
         if (p >= DEPTH) begin
            exp_fault = 1'b1;
            break;
         end
         sb.push_back('{pc: p, inst: mem[p[3:0]]});
         if (mem[p[3:0]][31:27] == HALT) break;
         p++;
      end
   endtask

   task automatic new_mem(input int halt_at);
      logic [31:0] w;
      for (int i = 0; i < DEPTH; i++) begin
         w = $urandom;
         if (w[31:27] == HALT) w[31:27] = 5'h00;
         mem[i] = w;
      end
      if (halt_at < DEPTH) mem[halt_at][31:27] = HALT;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      sb.delete();
      halt_pop_cyc = -1;
      exp_fault = 1'b0;
   endtask

   task automatic wait_halted(input int bound, output int seen);
      seen = -1;
      for (int i = 0; i < bound; i++) begin
         sample();
         if (halted) begin
            seen = cyc;
            break;
         end
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with start and redirect both asserted.
      new_mem(6);
      rst = 1'b1; start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd5; dec_ready = 1'b1;
      exp_fault = 1'b0;
      repeat (2) tick();
      sample();
      check("rst_imem_pc", 64'(imem_pc), 64'd0);
      check("rst_dec_valid", 64'(dec_valid), 64'd0);
      check("rst_dec_pc", 64'(dec_pc), 64'd0);
      check("rst_dec_inst", 64'(dec_inst), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_fault", 64'(fault), 64'd0);
      tick();
      rst = 1'b0; start = 1'b0;
      tick();
      redirect_valid = 1'b0;
      tick();
      sample();
      check("idle_imem_pc", 64'(imem_pc), 64'd0);
      check("idle_dec_valid", 64'(dec_valid), 64'd0);

      // Straight-line run to the HALT at 6.
      do_reset();
      build_stream(32'd0);
      dec_ready = 1'b1;
      pulse_start();
      sample();
      check("sl_c1_imem_pc", 64'(imem_pc), 64'd0);
      check("sl_c1_valid", 64'(dec_valid), 64'd0);
      tick();
      sample();
      check("sl_c2_valid", 64'(dec_valid), 64'd1);
      check("sl_c2_pc", 64'(dec_pc), 64'd0);
      wait_halted(40, seen_cyc);
      check("sl_halted", 64'(halted), 64'd1);
      check("sl_halt_latency", 64'(seen_cyc), 64'(halt_pop_cyc + 1));
      check("sl_fault", 64'(fault), 64'd0);
      check("sl_imem_pc_stop", 64'(imem_pc), 64'd7);
      check("sl_drained", 64'(sb.size()), 64'd0);

      // Back-pressure: decode stalls five cycles after start.
      do_reset();
      build_stream(32'd0);
      dec_ready = 1'b0;
      pulse_start();
      repeat (4) tick();
      sample();
      check("bp_imem_pc", 64'(imem_pc), 64'd2);
      check("bp_valid", 64'(dec_valid), 64'd1);
      check("bp_head_pc", 64'(dec_pc), 64'd0);
      tick();
      sample();
      check("bp_imem_pc_hold", 64'(imem_pc), 64'd2);
      tick();
      dec_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sample();
         check("bp_no_gap", 64'(dec_valid), 64'd1);
         tick();
      end
      wait_halted(40, seen_cyc);
      check("bp_halted", 64'(halted), 64'd1);
      check("bp_drained", 64'(sb.size()), 64'd0);

      // Redirect to 2 while PC 6 is being fetched and PC 5 is popped.
      do_reset();
      build_stream(32'd0);
      dec_ready = 1'b1;
      pulse_start();
      repeat (6) tick();
      check("rd_inflight_pc", 64'(imem_pc), 64'd6);
      redirect_valid = 1'b1;
      redirect_pc = 32'd2;
      sample();
      build_stream(32'd2);
      tick();
      redirect_valid = 1'b0;
      sample();
      check("rd_gap_valid", 64'(dec_valid), 64'd0);
      check("rd_target_fetch", 64'(imem_pc), 64'd2);
      check("rd_not_halted", 64'(halted), 64'd0);
      tick();
      sample();
      check("rd_target_valid", 64'(dec_valid), 64'd1);
      check("rd_target_pc", 64'(dec_pc), 64'd2);
      wait_halted(40, seen_cyc);
      check("rd_halted", 64'(halted), 64'd1);
      check("rd_fault", 64'(fault), 64'd0);
      check("rd_drained", 64'(sb.size()), 64'd0);

      // Fault: redirect out of range, then a redirect back must not revive.
      do_reset();
      build_stream(32'd0);
      dec_ready = 1'b1;
      pulse_start();
      repeat (2) tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'd20;
      sample();
      build_stream(32'd20);
      tick();
      redirect_valid = 1'b0;
      sample();
      check("ft_c4_valid", 64'(dec_valid), 64'd0);
      check("ft_c4_imem_pc", 64'(imem_pc), 64'd20);
      check("ft_c4_fault", 64'(fault), 64'd0);
      tick();
      sample();
      check("ft_fault_set", 64'(fault), 64'd1);
      check("ft_c5_valid", 64'(dec_valid), 64'd0);
      wait_halted(10, seen_cyc);
      check("ft_halted", 64'(halted), 64'd1);
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'd0;
      tick();
      redirect_valid = 1'b0;
      repeat (3) tick();
      sample();
      check("ft_hold_halted", 64'(halted), 64'd1);
      check("ft_hold_fault", 64'(fault), 64'd1);
      check("ft_hold_valid", 64'(dec_valid), 64'd0);
      check("ft_drained", 64'(sb.size()), 64'd0);
      do_reset();
      sample();
      check("ft_rst_fault", 64'(fault), 64'd0);
      check("ft_rst_halted", 64'(halted), 64'd0);

      // Randomized runs: random programs, random stalls and redirects.
      for (int run = 0; run < 25; run++) begin
         new_mem($urandom_range(0, 19));
         do_reset();
         build_stream(32'd0);
         dec_ready = 1'b1;
         pulse_start();
         for (int c = 0; c < 400 && !halted; c++) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            if (sb.size() >= 3 && $urandom_range(0, 9) == 0) begin
               tgt = 32'($urandom_range(0, 18));
               redirect_valid = 1'b1;
               redirect_pc = tgt;
               sample();
               build_stream(tgt);
            end else begin
               redirect_valid = 1'b0;
            end
            tick();
         end
         redirect_valid = 1'b0;
         check("rnd_halted", 64'(halted), 64'd1);
         check("rnd_drained", 64'(sb.size()), 64'd0);
         check("rnd_fault", 64'(fault), 64'(exp_fault));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
